pkt_rd_ctrl: RTL and testbench

- Avalon-MM burst read master upstream of the packet write controller.
- On a start command it reads packet bytes [pkt_begin, pkt_end) from packet memory and pushes 32-bit words into the shared packet FIFO.
- It pulses the write controller's start input and raises a done pulse once the last word is in the FIFO.
- Credit-based flow control guarantees the FIFO never overflows, with multiple read bursts outstanding.

---
 rtl/pkt_rd_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pkt_rd_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_rd_ctrl.sv
//==============================================================================
// pkt_rd_ctrl: credit-limited Avalon-MM burst reader that streams a packet's
// words into the shared packet FIFO.  Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module pkt_rd_ctrl #(
  parameter int BURST_SIZE_WORDS      = 4,
  parameter int FIFO_DEPTH            = 512,
  parameter int MAX_OUTSTANDING_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] pkt_begin,
  input  logic [31:0] pkt_end,
  output logic        busy,
  output logic        done,
  output logic        len_err,
  output logic        wr_ctrl,
  output logic [31:0] fifo_in,
  output logic        wr_to_fifo,
  input  logic        full,
  input  logic [8:0]  usedw,
  output logic [31:0] address,
  output logic        read,
  output logic [15:0] burstcount,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_REQ   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_FLUSH = 2'd3;

  localparam logic [31:0] c_BURST    = 32'(BURST_SIZE_WORDS);
  localparam logic [31:0] c_FIFO_LIM = 32'(FIFO_DEPTH - 1);
  localparam logic [31:0] c_MAX_OUT  = 32'(MAX_OUTSTANDING_WORDS);

  logic [1:0]  r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_len_err;
  logic        r_wr_ctrl;
  logic        r_read;
  logic [31:0] r_address;
  logic [15:0] r_burstcount;
  logic [31:0] r_next_addr;
  logic [31:0] r_req_left;
  logic [15:0] r_outstanding;

  logic [31:0] w_diff;
  logic        w_neg;
  logic [31:0] w_total;
  logic [31:0] w_bw;
  logic        w_credit_ok;
  logic        w_accept;
  logic        w_wr;
  logic [15:0] w_out_nxt;
  logic        w_unused_full;

  assign w_diff  = pkt_end - pkt_begin;
  assign w_neg   = pkt_end < pkt_begin;
  // ceil(len/4) without a 33-bit intermediate
  assign w_total = w_neg ? 32'd0 : ({2'b00, w_diff[31:2]} + {31'd0, |w_diff[1:0]});

  assign w_bw = (r_req_left < c_BURST) ? r_req_left : c_BURST;

  // Reserve FIFO room for every word already requested plus the new burst
  assign w_credit_ok = (({23'd0, usedw} + {16'd0, r_outstanding} + w_bw) <= c_FIFO_LIM) &&
                       (({16'd0, r_outstanding} + w_bw) <= c_MAX_OUT);

  assign w_accept  = r_read & ~waitrequest;
  assign w_wr      = readdatavalid & r_busy;
  assign w_out_nxt = r_outstanding + (w_accept ? r_burstcount : 16'd0) - {15'd0, w_wr};

  // Credit accounting makes a full FIFO unreachable, so full carries no control role
  assign w_unused_full = full;

  assign busy       = r_busy;
  assign done       = r_done;
  assign len_err    = r_len_err;
  assign wr_ctrl    = r_wr_ctrl;
  assign read       = r_read;
  assign address    = r_address;
  assign burstcount = r_burstcount;
  assign wr_to_fifo = w_wr;
  assign fifo_in    = w_wr ? readdata : 32'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= c_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_len_err     <= 1'b0;
      r_wr_ctrl     <= 1'b0;
      r_read        <= 1'b0;
      r_address     <= 32'd0;
      r_burstcount  <= 16'd0;
      r_next_addr   <= 32'd0;
      r_req_left    <= 32'd0;
      r_outstanding <= 16'd0;
    end else begin
      r_done        <= 1'b0;
      r_wr_ctrl     <= 1'b0;
      r_outstanding <= w_out_nxt;

      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_next_addr   <= {pkt_begin[31:2], 2'b00};
            r_req_left    <= w_total;
            r_len_err     <= w_neg;
            r_busy        <= 1'b1;
            r_wr_ctrl     <= 1'b1;
            r_outstanding <= 16'd0;
            r_state       <= (w_total == 32'd0) ? c_FLUSH : c_REQ;
          end
        end

        c_REQ: begin
          if (r_read) begin
            if (!waitrequest) begin
              r_read      <= 1'b0;
              r_next_addr <= r_next_addr + {14'd0, r_burstcount, 2'b00};
              r_req_left  <= r_req_left - {16'd0, r_burstcount};
              if (r_req_left == {16'd0, r_burstcount}) begin
                r_state <= c_DRAIN;
              end
            end
          end else if (w_credit_ok) begin
            r_read       <= 1'b1;
            r_address    <= r_next_addr;
            r_burstcount <= w_bw[15:0];
          end
        end

        c_DRAIN: begin
          if (w_out_nxt == 16'd0) begin
            r_state <= c_FLUSH;
            r_done  <= 1'b1;
          end
        end

        c_FLUSH: begin
          // The done cycle is spent in FLUSH; busy falls on the way out
          if (r_done) begin
            r_state <= c_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_done <= 1'b1;
          end
        end

        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pkt_rd_ctrl.sv
//==============================================================================
// tb_pkt_rd_ctrl: directed plus randomized packets against a word-level model
// of the reader (burst plan, credit rule, FIFO write stream, done timing). Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pkt_rd_ctrl;

  localparam int BS   = 4;
  localparam int DEPTH = 512;
  localparam int MAXO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pkt_begin;
  logic [31:0] pkt_end;
  logic        busy;
  logic        done;
  logic        len_err;
  logic        wr_ctrl;
  logic [31:0] fifo_in;
  logic        wr_to_fifo;
  logic        full;
  logic [8:0]  usedw;
  logic [31:0] address;
  logic        read;
  logic [15:0] burstcount;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] seed;

  always #5 clk = ~clk;

  pkt_rd_ctrl #(
    .BURST_SIZE_WORDS     (BS),
    .FIFO_DEPTH           (DEPTH),
    .MAX_OUTSTANDING_WORDS(MAXO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pkt_begin    (pkt_begin),
    .pkt_end      (pkt_end),
    .busy         (busy),
    .done         (done),
    .len_err      (len_err),
    .wr_ctrl      (wr_ctrl),
    .fifo_in      (fifo_in),
    .wr_to_fifo   (wr_to_fifo),
    .full         (full),
    .usedw        (usedw),
    .address      (address),
    .read         (read),
    .burstcount   (burstcount),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},   32'(busy),       32'd0);
    chk({tag, "_done"},   32'(done),       32'd0);
    chk({tag, "_wrctl"},  32'(wr_ctrl),    32'd0);
    chk({tag, "_read"},   32'(read),       32'd0);
    chk({tag, "_addr"},   address,         32'd0);
    chk({tag, "_bc"},     32'(burstcount), 32'd0);
    chk({tag, "_wr"},     32'(wr_to_fifo), 32'd0);
    chk({tag, "_fifoin"}, fifo_in,         32'd0);
  endtask

  // One packet, cycle by cycle: inputs driven and outputs sampled at negedge.
  task automatic run_pkt(input logic [31:0] b, input logic [31:0] e,
                         input int wait_pct, input int first_wait, input int rdv_pct,
                         input logic [8:0] uw_a, input logic [8:0] uw_b, input int uw_switch,
                         input int abort_out);
    logic        exp_err;
    longint      d;
    int          total, req_words, written, out_cur, out_prev, done_k, bursts, hold_cnt, k, nb;
    logic [31:0] base, hold_addr, data_exp;
    logic [15:0] hold_bc;
    logic        holding, rd, wreq, rdv;
    logic [8:0]  uw_prev;
    logic [31:0] addr_q[$];

    exp_err   = (e < b);
    d         = longint'({32'd0, e - b});
    total     = exp_err ? 0 : int'((d + 3) >>> 2);
    base      = {b[31:2], 2'b00};
    req_words = 0; written = 0; out_cur = 0; out_prev = 0; bursts = 0; hold_cnt = 0;
    holding   = 1'b0; hold_addr = 32'd0; hold_bc = 16'd0;
    done_k    = (total == 0) ? 2 : -1;
    addr_q    = {};

    @(negedge clk);
    start = 1'b1; pkt_begin = b; pkt_end = e; usedw = uw_a;
    waitrequest = 1'b0; readdatavalid = 1'b0;
    uw_prev = uw_a;
    @(negedge clk);
    start = 1'b0;

    for (k = 1; k < 2000; k++) begin
      rd = read;
      chk("wr_ctrl", 32'(wr_ctrl), 32'(k == 1));
      chk("busy",    32'(busy),    32'(done_k < 0 || k <= done_k));
      chk("done",    32'(done),    32'(k == done_k));
      chk("len_err", 32'(len_err), 32'(exp_err));

      if (holding) begin
        chk("hold_read", 32'(rd),         32'd1);
        chk("hold_addr", address,         hold_addr);
        chk("hold_bc",   32'(burstcount), 32'(hold_bc));
      end else if (rd) begin
        if (req_words >= total) begin
          chk("extra_burst", 32'(rd), 32'd0);
        end else begin
          hold_addr = base + 32'(4 * req_words);
          hold_bc   = 16'((total - req_words < BS) ? total - req_words : BS);
          chk("burst_addr", address,         hold_addr);
          chk("burst_bc",   32'(burstcount), 32'(hold_bc));
          chk("credit", 32'((int'(uw_prev) + out_prev + int'(hold_bc) <= DEPTH - 1) &&
                            (out_prev + int'(hold_bc) <= MAXO)), 32'd1);
        end
      end

      wreq = rd && ((bursts == 0 && hold_cnt < first_wait) ||
                    ($urandom_range(0, 99) < 32'(wait_pct)));
      rdv  = (addr_q.size() > 0) && (abort_out == 0) &&
             ($urandom_range(0, 99) < 32'(rdv_pct));
      data_exp      = rdv ? mem(addr_q[0]) : $urandom;
      waitrequest   = wreq;
      readdatavalid = rdv;
      readdata      = data_exp;
      usedw         = (k < uw_switch) ? uw_a : uw_b;
      #1;
      chk("wr_to_fifo", 32'(wr_to_fifo), 32'(rdv));
      if (rdv) chk("fifo_in", fifo_in, data_exp);

      out_prev = out_cur;
      uw_prev  = usedw;
      if (rd && req_words < total) begin
        if (!wreq) begin
          for (int i = 0; i < int'(hold_bc); i++) addr_q.push_back(base + 32'(4 * (req_words + i)));
          req_words += int'(hold_bc);
          out_cur   += int'(hold_bc);
          bursts++;
          holding  = 1'b0;
          hold_cnt = 0;
        end else begin
          holding = 1'b1;
          hold_cnt++;
        end
      end
      if (rdv) begin
        void'(addr_q.pop_front());
        out_cur--;
        written++;
        if (written == total) done_k = k + 1;
      end
      if (abort_out > 0 && out_cur >= abort_out) return;
      if (done_k > 0 && k >= done_k + 2) break;
      @(negedge clk);
    end

    waitrequest = 1'b0; readdatavalid = 1'b0;
    nb = (total + BS - 1) / BS;
    chk("completed", 32'(done_k > 0 && k >= done_k + 2), 32'd1);
    chk("bursts",    32'(bursts),  32'(nb));
    chk("words",     32'(written), 32'(total));
  endtask

  initial begin
    seed = $urandom;
    reset = 1'b0; start = 1'b0; pkt_begin = 32'd0; pkt_end = 32'd0;
    full = 1'b0; usedw = 9'd0; waitrequest = 1'b0; readdata = 32'd0; readdatavalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_len_err", 32'(len_err), 32'd0);
    reset = 1'b1;

    // 16 words, four bursts of four, no stalls
    run_pkt(32'h1000, 32'h1040, 0, 0, 100, 9'd0, 9'd0, 0, 0);
    // trailing partial word, then 4 + 2 bursts
    run_pkt(32'h1000, 32'h100E, 0, 0, 100, 9'd0, 9'd0, 0, 0);
    run_pkt(32'h1000, 32'h1016, 0, 0, 100, 9'd0, 9'd0, 0, 0);
    // first burst held off by waitrequest for 5 cycles
    run_pkt(32'h3000, 32'h3010, 0, 5, 100, 9'd0, 9'd0, 0, 0);
    // FIFO nearly full until cycle 30
    run_pkt(32'h4000, 32'h4080, 0, 0, 80, 9'd508, 9'd506, 30, 0);
    // negative length, then a valid packet clears len_err
    run_pkt(32'h2000, 32'h1FF0, 0, 0, 100, 9'd0, 9'd0, 0, 0);
    run_pkt(32'h2002, 32'h2023, 20, 0, 60, 9'd0, 9'd0, 0, 0);
    // zero length
    run_pkt(32'h2400, 32'h2400, 0, 0, 100, 9'd0, 9'd0, 0, 0);

    // reset with 8 words outstanding, then stray read data
    run_pkt(32'h5000, 32'h5080, 0, 0, 0, 9'd0, 9'd0, 0, 8);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk_idle_outputs("mid_reset");
    for (int i = 0; i < 8; i++) begin
      readdatavalid = 1'b1;
      readdata      = $urandom;
      #1;
      chk("stray_wr",     32'(wr_to_fifo), 32'd0);
      chk("stray_fifoin", fifo_in,         32'd0);
      @(negedge clk);
    end
    readdatavalid = 1'b0;
    chk_idle_outputs("post_stray");
    run_pkt(32'h6000, 32'h6040, 10, 0, 70, 9'd0, 9'd0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      logic [31:0] rb, re;
      rb = $urandom_range(32'h0010_0000, 32'h0FFF_0000);
      re = (r == 5) ? rb - 32'd3 : rb + $urandom_range(0, 160);
      run_pkt(rb, re, int'($urandom_range(0, 60)), int'($urandom_range(0, 3)),
              int'($urandom_range(30, 100)), 9'($urandom_range(0, 480)),
              9'($urandom_range(0, 480)), int'($urandom_range(0, 40)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
